// File: rtl/sevseg_pkg.sv
// Shared constants, types and helpers for the seven-segment scan engine.
package sevseg_pkg;

   localparam logic [7:0] ADDR_CTRL       = 8'h00;
   localparam logic [7:0] ADDR_DIGIT_EN   = 8'h04;
   localparam logic [7:0] ADDR_MODE       = 8'h08;
   localparam logic [7:0] ADDR_DP         = 8'h0C;
   localparam logic [7:0] ADDR_BLINK_MASK = 8'h10;
   localparam logic [7:0] ADDR_DATA0      = 8'h20;
   localparam logic [7:0] ADDR_STATUS     = 8'h30;

   // Segment bit order is g..a, bit0 = a, active-high.
   localparam logic [6:0] GLYPH_BLANK = 7'h00;
   localparam logic [6:0] GLYPH_MINUS = 7'h40;
   localparam logic [6:0] GLYPH_UNDER = 7'h08;

   typedef struct packed {
      logic [7:0] blink_div;
      logic [3:0] brightness;
      logic       enable;
   } ctrl_t;

   // Clocks per digit slot; never below one so the scan always advances.
   function automatic int unsigned slot_div(input int unsigned clk_hz,
                                            input int unsigned refresh_hz,
                                            input int unsigned digits);
      int unsigned d;
      d = clk_hz / (refresh_hz * digits);
      return (d == 0) ? 1 : d;
   endfunction

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/sevseg_glyph_rom.sv
// Character code to active-high segment pattern; polarity is applied by the caller.
module sevseg_glyph_rom
   import sevseg_pkg::*;
(
   input  logic       ascii_i,
   input  logic [7:0] code_i,
   output logic [6:0] seg_o
);

   logic [7:0] code_f;

   // Hex mode uses the low nibble; ASCII folds lowercase onto uppercase glyphs.
   always_comb begin
      code_f = code_i;
      if (code_i >= 8'h61 && code_i <= 8'h7A) code_f = code_i - 8'h20;
      seg_o = GLYPH_BLANK;
      if (!ascii_i) begin
         seg_o = hex_glyph(code_i[3:0]);
      end else if (code_f >= 8'h30 && code_f <= 8'h39) begin
         seg_o = hex_glyph(code_f[3:0]);
      end else begin
         case (code_f)
            8'h41: seg_o = 7'h77;
            8'h42: seg_o = 7'h7C;
            8'h43: seg_o = 7'h39;
            8'h44: seg_o = 7'h5E;
            8'h45: seg_o = 7'h79;
            8'h46: seg_o = 7'h71;
            8'h47: seg_o = 7'h3D;
            8'h48: seg_o = 7'h76;
            8'h49: seg_o = 7'h30;
            8'h4A: seg_o = 7'h1E;
            8'h4B: seg_o = 7'h75;
            8'h4C: seg_o = 7'h38;
            8'h4D: seg_o = 7'h37;
            8'h4E: seg_o = 7'h54;
            8'h4F: seg_o = 7'h3F;
            8'h50: seg_o = 7'h73;
            8'h51: seg_o = 7'h67;
            8'h52: seg_o = 7'h50;
            8'h53: seg_o = 7'h6D;
            8'h54: seg_o = 7'h78;
            8'h55: seg_o = 7'h3E;
            8'h56: seg_o = 7'h1C;
            8'h57: seg_o = 7'h2A;
            8'h58: seg_o = 7'h76;
            8'h59: seg_o = 7'h6E;
            8'h5A: seg_o = 7'h5B;
            8'h2D: seg_o = GLYPH_MINUS;
            8'h5F: seg_o = GLYPH_UNDER;
            default: seg_o = GLYPH_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/sevseg_scan_engine.sv
// N-digit multiplexed seven-segment engine with its own Wishbone register slave.
module sevseg_scan_engine
   import sevseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 8,
   parameter int unsigned CLK_FREQ_HZ = 50000000,
   parameter int unsigned REFRESH_HZ  = 1000,
   parameter int unsigned ACTIVE_LOW  = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [7:0]            i_wb_adr,
   input  logic [31:0]           i_wb_dat,
   input  logic [3:0]            i_wb_sel,
   input  logic                  i_wb_we,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   output logic [31:0]           o_wb_rdt,
   output logic                  o_wb_ack,
   output logic [NUM_DIGITS-1:0] o_an,
   output logic [6:0]            o_seg,
   output logic                  o_dp,
   output logic                  o_frame_tick
);

   localparam int unsigned N        = NUM_DIGITS;
   localparam int unsigned SLOT_DIV = slot_div(CLK_FREQ_HZ, REFRESH_HZ, NUM_DIGITS);
   localparam int unsigned PRE_W    = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(SLOT_DIV - 1);
   localparam logic [3:0]       IDX_LAST = 4'(N - 1);
   localparam logic             POL      = (ACTIVE_LOW != 0);

   ctrl_t           ctrl_q, ctrl_d;
   logic [N-1:0]    den_q, den_d, mode_q, mode_d, dp_q, dp_d, bmask_q, bmask_d;
   logic [7:0]      data_q [N];
   logic [7:0]      data_d [N];
   logic            ack_q;
   logic [31:0]     rdt_q, rdt_d;
   logic            wb_req, wb_wr;

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [3:0]       idx_q, idx_d;
   logic [15:0]      frame_q, frame_d;
   logic [3:0]       pwm_q;
   logic [7:0]       half_q, half_d;
   logic             boff_q, boff_d;
   logic             tick_q, slot_tc, wrap;

   logic [N-1:0]    one_hot, an_q, an_d;
   logic            cur_en, cur_mode, cur_dp, cur_blink;
   logic [7:0]      cur_code;
   logic [6:0]      cur_glyph, seg_q, seg_d;
   logic            dp_q_pin, dp_d_pin;
   logic            pwm_on, blink_off, lit;

   function automatic logic [7:0] data_addr(input int i);
      return ADDR_DATA0 + 8'(4 * (i / 4));
   endfunction

   function automatic logic [N-1:0] upd_bits(input logic [N-1:0] old,
                                             input logic [31:0] dat,
                                             input logic [3:0] sel);
      logic [N-1:0] r;
      r = old;
      for (int b = 0; b < N; b++)
         if (sel[b / 8]) r[b] = dat[b];
      return r;
   endfunction

   assign wb_req = i_wb_cyc & i_wb_stb & ~ack_q;
   assign wb_wr  = wb_req & i_wb_we;

   // Register writes, byte-lane masked; they land on the same edge that raises ack.
   always_comb begin
      ctrl_d  = ctrl_q;
      den_d   = den_q;
      mode_d  = mode_q;
      dp_d    = dp_q;
      bmask_d = bmask_q;
      data_d  = data_q;
      if (wb_wr) begin
         case (i_wb_adr)
            ADDR_CTRL: begin
               if (i_wb_sel[0]) begin
                  ctrl_d.enable     = i_wb_dat[0];
                  ctrl_d.brightness = i_wb_dat[7:4];
               end
               if (i_wb_sel[2]) ctrl_d.blink_div = i_wb_dat[23:16];
            end
            ADDR_DIGIT_EN:   den_d   = upd_bits(den_q, i_wb_dat, i_wb_sel);
            ADDR_MODE:       mode_d  = upd_bits(mode_q, i_wb_dat, i_wb_sel);
            ADDR_DP:         dp_d    = upd_bits(dp_q, i_wb_dat, i_wb_sel);
            ADDR_BLINK_MASK: bmask_d = upd_bits(bmask_q, i_wb_dat, i_wb_sel);
            default: ;
         endcase
         for (int i = 0; i < N; i++)
            if (i_wb_adr == data_addr(i) && i_wb_sel[i % 4])
               data_d[i] = i_wb_dat[8*(i%4) +: 8];
      end
   end

   // Read mux; unmapped words and bits beyond NUM_DIGITS return zero.
   always_comb begin
      rdt_d = '0;
      if (wb_req && !i_wb_we) begin
         case (i_wb_adr)
            ADDR_CTRL:       rdt_d = {8'h00, ctrl_q.blink_div, 8'h00, ctrl_q.brightness,
                                      3'b000, ctrl_q.enable};
            ADDR_DIGIT_EN:   rdt_d = 32'(den_q);
            ADDR_MODE:       rdt_d = 32'(mode_q);
            ADDR_DP:         rdt_d = 32'(dp_q);
            ADDR_BLINK_MASK: rdt_d = 32'(bmask_q);
            ADDR_STATUS:     rdt_d = {frame_q, 12'h000, idx_q};
            default: ;
         endcase
         for (int i = 0; i < N; i++)
            if (i_wb_adr == data_addr(i)) rdt_d[8*(i%4) +: 8] = data_q[i];
      end
   end

   // Bus handshake and configuration registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ack_q   <= 1'b0;
         rdt_q   <= '0;
         ctrl_q  <= '0;
         den_q   <= '0;
         mode_q  <= '0;
         dp_q    <= '0;
         bmask_q <= '0;
         for (int i = 0; i < N; i++) data_q[i] <= '0;
      end else begin
         ack_q   <= wb_req;
         rdt_q   <= rdt_d;
         ctrl_q  <= ctrl_d;
         den_q   <= den_d;
         mode_q  <= mode_d;
         dp_q    <= dp_d;
         bmask_q <= bmask_d;
         data_q  <= data_d;
      end
   end

   assign slot_tc = (pre_q == PRE_TC);
   assign wrap    = ctrl_q.enable & slot_tc & (idx_q == IDX_LAST);

   // Slot prescaler, scan index, frame counter and blink half-period tracking.
   always_comb begin
      pre_d   = '0;
      idx_d   = '0;
      frame_d = frame_q + {15'h0000, wrap};
      half_d  = half_q;
      boff_d  = boff_q;
      if (ctrl_q.enable) begin
         pre_d = slot_tc ? '0 : pre_q + 1'b1;
         idx_d = idx_q;
         if (slot_tc) idx_d = wrap ? 4'h0 : idx_q + 4'h1;
      end
      // A new divider restarts the blink phase so software sees a clean first half.
      if (ctrl_d.blink_div != ctrl_q.blink_div || ctrl_q.blink_div == 8'h00) begin
         half_d = '0;
         boff_d = 1'b0;
      end else if (wrap) begin
         if (half_q == ctrl_q.blink_div - 8'h01) begin
            half_d = '0;
            boff_d = ~boff_q;
         end else begin
            half_d = half_q + 8'h01;
         end
      end
   end

   // Scan timing state; the PWM counter free-runs independently of enable.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         pre_q   <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         pwm_q   <= '0;
         half_q  <= '0;
         boff_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         pwm_q   <= pwm_q + 4'h1;
         half_q  <= half_d;
         boff_q  <= boff_d;
         tick_q  <= wrap;
      end
   end

   // Select the current digit's settings by scan index.
   always_comb begin
      one_hot   = '0;
      cur_en    = 1'b0;
      cur_mode  = 1'b0;
      cur_dp    = 1'b0;
      cur_blink = 1'b0;
      cur_code  = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == 4'(i)) begin
            one_hot[i] = 1'b1;
            cur_en     = den_q[i];
            cur_mode   = mode_q[i];
            cur_dp     = dp_q[i];
            cur_blink  = bmask_q[i];
            cur_code   = data_q[i];
         end
      end
   end

   sevseg_glyph_rom u_glyph (
      .ascii_i (cur_mode),
      .code_i  (cur_code),
      .seg_o   (cur_glyph)
   );

   assign pwm_on    = (ctrl_q.brightness == 4'hF) | (pwm_q < ctrl_q.brightness);
   assign blink_off = boff_q & (ctrl_q.blink_div != 8'h00);
   assign lit       = ctrl_q.enable & cur_en & pwm_on & ~(cur_blink & blink_off);

   // Gate everything on lit, then apply pin polarity.
   always_comb begin
      an_d     = (lit ? one_hot : '0) ^ {N{POL}};
      seg_d    = (lit ? cur_glyph : GLYPH_BLANK) ^ {7{POL}};
      dp_d_pin = (lit & cur_dp) ^ POL;
   end

   // Registered pin stage; reset drives every pin to its inactive level.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         an_q     <= {N{POL}};
         seg_q    <= {7{POL}};
         dp_q_pin <= POL;
      end else begin
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q_pin <= dp_d_pin;
      end
   end

   assign o_wb_ack     = ack_q;
   assign o_wb_rdt     = rdt_q;
   assign o_an         = an_q;
   assign o_seg        = seg_q;
   assign o_dp         = dp_q_pin;
   assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_sevseg_scan_engine.sv
// Directed bench for sevseg_scan_engine with an 8-cycle slot and 64-cycle frame.
module tb_sevseg_scan_engine;

   localparam logic [7:0] A_CTRL = 8'h00, A_DEN = 8'h04, A_MODE = 8'h08, A_DP = 8'h0C;
   localparam logic [7:0] A_BMASK = 8'h10, A_DATA0 = 8'h20, A_DATA1 = 8'h24;
   localparam logic [7:0] A_DATA2 = 8'h28, A_DATA3 = 8'h2C, A_STATUS = 8'h30;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  wb_adr = '0;
   logic [31:0] wb_dat = '0;
   logic [3:0]  wb_sel = '0;
   logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;
   logic [7:0]  o_an;
   logic [6:0]  o_seg;
   logic        o_dp, o_frame_tick;

   int n_cmp = 0;
   int n_err = 0;

   logic [6:0] hex_g [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   always #5 clk = ~clk;

   sevseg_scan_engine #(
      .NUM_DIGITS(8), .CLK_FREQ_HZ(8000), .REFRESH_HZ(125), .ACTIVE_LOW(1)
   ) dut (
      .i_clk(clk), .i_rst(rst_n), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat),
      .i_wb_sel(wb_sel), .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb),
      .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_an(o_an), .o_seg(o_seg),
      .o_dp(o_dp), .o_frame_tick(o_frame_tick)
   );

   // ackp = {ack before edge, ack after first edge, ack after second edge}
   task automatic wb_xfer(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                          input logic we, output logic [31:0] rdt, output logic [2:0] ackp);
      @(negedge clk);
      wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
      #1 ackp[2] = o_wb_ack;
      @(posedge clk); #1;
      ackp[1] = o_wb_ack;
      rdt = o_wb_rdt;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      @(posedge clk); #1;
      ackp[0] = o_wb_ack;
   endtask

   task automatic wb_wr(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] r;
      logic [2:0]  a;
      wb_xfer(adr, dat, sel, 1'b1, r, a);
   endtask

   task automatic wb_rd(input logic [7:0] adr, output logic [31:0] rdt);
      logic [2:0] a;
      wb_xfer(adr, 32'h0, 4'hF, 1'b0, rdt, a);
   endtask

   task automatic wait_an(input logic [7:0] want, output bit found);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (o_an === want) found = 1'b1;
      end
   endtask

   task automatic wait_tick(output bit found);
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         @(negedge clk);
         if (o_frame_tick === 1'b1) found = 1'b1;
      end
   endtask

   task automatic test_reset;
      logic [7:0]  addrs [10] = '{A_CTRL, A_DEN, A_MODE, A_DP, A_BMASK,
                                  A_DATA0, A_DATA1, A_DATA2, A_DATA3, A_STATUS};
      logic [31:0] r;
      logic [2:0]  a;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (o_an !== 8'hFF) begin n_err++; $display("FAIL reset_an: got %h want ff", o_an); end
      n_cmp++; if (o_seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg: got %h want 7f", o_seg); end
      n_cmp++; if (o_dp !== 1'b1) begin n_err++; $display("FAIL reset_dp: got %b want 1", o_dp); end
      n_cmp++; if (o_frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", o_frame_tick); end
      n_cmp++; if (o_wb_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", o_wb_ack); end
      n_cmp++; if (o_wb_rdt !== 32'h0) begin n_err++; $display("FAIL reset_rdt: got %h want 0", o_wb_rdt); end
      rst_n = 1'b1;
      foreach (addrs[i]) begin
         wb_xfer(addrs[i], 32'h0, 4'hF, 1'b0, r, a);
         n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_read[%h]: got %h want 0", addrs[i], r); end
         n_cmp++; if (a !== 3'b010) begin n_err++; $display("FAIL reset_ack_timing[%h]: got %b want 010", addrs[i], a); end
      end
   endtask

   task automatic test_reg_map;
      logic [31:0] r;
      wb_wr(8'h14, 32'hFFFF_FFFF, 4'hF);
      wb_rd(8'h14, r);
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL unmapped_rd: got %h want 0", r); end
      wb_wr(A_DEN, 32'hFFFF_FFFF, 4'hF);
      wb_rd(A_DEN, r);
      n_cmp++; if (r !== 32'h0000_00FF) begin n_err++; $display("FAIL den_width: got %h want ff", r); end
      wb_wr(A_DP, 32'h0000_FFFF, 4'b0010);
      wb_rd(A_DP, r);
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL dp_upper_byte: got %h want 0", r); end
      wb_wr(A_DATA2, 32'h1234_5678, 4'hF);
      wb_rd(A_DATA2, r);
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL data_beyond: got %h want 0", r); end
      wb_wr(A_CTRL, 32'hFFFF_FFFF, 4'hF);
      wb_rd(A_CTRL, r);
      n_cmp++; if (r !== 32'h00FF_00F1) begin n_err++; $display("FAIL ctrl_fields: got %h want 00ff00f1", r); end
      wb_wr(A_CTRL, 32'h0, 4'hF);
      wb_wr(A_DEN, 32'h0, 4'hF);
   endtask

   task automatic test_scan;
      bit         found;
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      int         cnt;
      wb_wr(A_DATA0, 32'h0403_0201, 4'hF);
      wb_wr(A_DATA1, 32'h0807_0605, 4'hF);
      wb_wr(A_DEN, 32'h0000_00FF, 4'hF);
      wb_wr(A_CTRL, 32'h0000_00F1, 4'hF);
      wait_an(8'hFE, found);
      n_cmp++; if (!found) begin n_err++; $display("FAIL scan_start: digit 0 never lit, an=%h", o_an); end
      for (int d = 0; d < 8; d++) begin
         for (int c = 0; c < 8; c++) begin
            if (d != 0 || c != 0) @(negedge clk);
            exp_an  = ~(8'h01 << d);
            exp_seg = ~hex_g[d+1];
            n_cmp++; if (o_an !== exp_an) begin n_err++; $display("FAIL scan_an d%0d c%0d: got %h want %h", d, c, o_an, exp_an); end
            n_cmp++; if (o_seg !== exp_seg) begin n_err++; $display("FAIL scan_seg d%0d c%0d: got %h want %h", d, c, o_seg, exp_seg); end
         end
      end
      wait_tick(found);
      n_cmp++; if (!found) begin n_err++; $display("FAIL tick_first: no frame tick seen"); end
      @(negedge clk);
      n_cmp++; if (o_frame_tick !== 1'b0) begin n_err++; $display("FAIL tick_width: got %b want 0", o_frame_tick); end
      cnt = 1;
      while (o_frame_tick !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
      n_cmp++; if (cnt !== 64) begin n_err++; $display("FAIL tick_period: got %0d want 64", cnt); end
   endtask

   task automatic test_ascii;
      bit found;
      wb_wr(A_MODE, 32'h01, 4'hF);
      wb_wr(A_DATA0, 32'h41, 4'b0001);
      wb_wr(A_DP, 32'h01, 4'hF);
      wait_an(8'hFE, found);
      n_cmp++; if (!found || o_seg !== 7'h08) begin n_err++; $display("FAIL ascii_A: got %h want 08", o_seg); end
      n_cmp++; if (o_dp !== 1'b0) begin n_err++; $display("FAIL dp_on: got %b want 0", o_dp); end
      wait_an(8'hFD, found);
      n_cmp++; if (!found || o_seg !== 7'h24) begin n_err++; $display("FAIL hex_neighbour: got %h want 24", o_seg); end
      n_cmp++; if (o_dp !== 1'b1) begin n_err++; $display("FAIL dp_off: got %b want 1", o_dp); end
      wb_wr(A_DATA0, 32'h7F, 4'b0001);
      wait_an(8'hFE, found);
      n_cmp++; if (!found || o_seg !== 7'h7F) begin n_err++; $display("FAIL ascii_7f: got %h want 7f", o_seg); end
      wb_wr(A_DATA0, 32'h2D, 4'b0001);
      wait_an(8'hFE, found);
      n_cmp++; if (!found || o_seg !== 7'h3F) begin n_err++; $display("FAIL ascii_minus: got %h want 3f", o_seg); end
      wb_wr(A_DATA0, 32'h61, 4'b0001);
      wait_an(8'hFE, found);
      n_cmp++; if (!found || o_seg !== 7'h08) begin n_err++; $display("FAIL ascii_a_fold: got %h want 08", o_seg); end
      wb_wr(A_DP, 32'h0, 4'hF);
   endtask

   task automatic test_brightness;
      int act, multi;
      wb_wr(A_CTRL, 32'h41, 4'b0001);
      repeat (2) @(negedge clk);
      act = 0; multi = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (o_an !== 8'hFF) act++;
         if ($countones(~o_an) > 1) multi++;
      end
      n_cmp++; if (act !== 16) begin n_err++; $display("FAIL pwm4_duty: got %0d want 16", act); end
      n_cmp++; if (multi !== 0) begin n_err++; $display("FAIL one_anode: got %0d want 0", multi); end
      wb_wr(A_CTRL, 32'h01, 4'b0001);
      repeat (2) @(negedge clk);
      act = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (o_an !== 8'hFF) act++;
      end
      n_cmp++; if (act !== 0) begin n_err++; $display("FAIL pwm0_blank: got %0d want 0", act); end
      wb_wr(A_CTRL, 32'hF1, 4'b0001);
   endtask

   task automatic test_blink;
      bit found, seen1, seen2;
      bit exp1 [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      wb_wr(A_BMASK, 32'h02, 4'hF);
      wb_wr(A_CTRL, 32'h0002_00F1, 4'hF);
      for (int f = 1; f <= 6; f++) begin
         wait_tick(found);
         n_cmp++; if (!found) begin n_err++; $display("FAIL blink_tick f%0d: no tick", f); end
         seen1 = 1'b0; seen2 = 1'b0;
         repeat (63) begin
            @(negedge clk);
            if (o_an[1] === 1'b0) seen1 = 1'b1;
            if (o_an[2] === 1'b0) seen2 = 1'b1;
         end
         n_cmp++; if (seen1 !== exp1[f]) begin n_err++; $display("FAIL blink_d1 f%0d: got %b want %b", f, seen1, exp1[f]); end
         n_cmp++; if (seen2 !== 1'b1) begin n_err++; $display("FAIL blink_d2 f%0d: got %b want 1", f, seen2); end
      end
      wb_wr(A_BMASK, 32'h0, 4'hF);
      wb_wr(A_CTRL, 32'h0000_00F1, 4'hF);
   endtask

   task automatic test_byte_sel;
      logic [31:0] r;
      bit found;
      wb_wr(A_DATA0, 32'hEEEE_AAEE, 4'b0010);
      wb_rd(A_DATA0, r);
      n_cmp++; if (r !== 32'h0403_AA61) begin n_err++; $display("FAIL bytesel_data0: got %h want 0403aa61", r); end
      wb_rd(A_DATA1, r);
      n_cmp++; if (r !== 32'h0807_0605) begin n_err++; $display("FAIL bytesel_data1: got %h want 08070605", r); end
      wait_an(8'hFD, found);
      n_cmp++; if (!found || o_seg !== 7'h08) begin n_err++; $display("FAIL bytesel_d1: got %h want 08", o_seg); end
      wait_an(8'hFB, found);
      n_cmp++; if (!found || o_seg !== 7'h30) begin n_err++; $display("FAIL bytesel_d2: got %h want 30", o_seg); end
   endtask

   task automatic test_reset_midslot;
      bit found;
      int act;
      logic [31:0] r;
      wait_an(8'hFB, found);
      n_cmp++; if (!found) begin n_err++; $display("FAIL midslot_pre: digit 2 never lit"); end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (o_an !== 8'hFF) begin n_err++; $display("FAIL async_an: got %h want ff", o_an); end
      n_cmp++; if (o_seg !== 7'h7F) begin n_err++; $display("FAIL async_seg: got %h want 7f", o_seg); end
      n_cmp++; if (o_dp !== 1'b1) begin n_err++; $display("FAIL async_dp: got %b want 1", o_dp); end
      @(negedge clk);
      wb_adr = A_CTRL; wb_dat = 32'hF1; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (o_wb_ack !== 1'b0) begin n_err++; $display("FAIL ack_in_reset: got %b want 0", o_wb_ack); end
      @(negedge clk);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      act = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_an !== 8'hFF) act++;
      end
      n_cmp++; if (act !== 0) begin n_err++; $display("FAIL post_reset_dark: got %0d want 0", act); end
      wb_rd(A_STATUS, r);
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL post_reset_status: got %h want 0", r); end
      wb_rd(A_CTRL, r);
      n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL post_reset_ctrl: got %h want 0", r); end
      wb_wr(A_DEN, 32'hFF, 4'hF);
      wb_wr(A_CTRL, 32'hF1, 4'hF);
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge clk);
         if (o_an !== 8'hFF) found = 1'b1;
      end
      n_cmp++; if (o_an !== 8'hFE) begin n_err++; $display("FAIL restart_idx0: got %h want fe", o_an); end
   endtask

   initial begin
      test_reset();
      test_reg_map();
      test_scan();
      test_ascii();
      test_brightness();
      test_blink();
      test_byte_sel();
      test_reset_midslot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sevseg_scan_engine.md
Name: sevseg_scan_engine

Overview:
- Parametrised next-generation seven-segment display engine for the VeeRwolf system controller.
- Replaces the fixed 8-digit display path with an N-digit multiplexer that has its own Wishbone register slave.
- Adds per-digit hex/ASCII mode, decimal points, PWM brightness, per-digit blink and a frame tick.
- Sits beside the syscon on the peripheral Wishbone bus and drives board anodes and segments directly.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits, 1..16.
- CLK_FREQ_HZ, 50000000, i_clk frequency.
- REFRESH_HZ, 1000, full-frame refresh rate.
- ACTIVE_LOW, 1, 1 means o_an/o_seg/o_dp are driven low when lit.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_wb_adr  in  8  byte address, word aligned.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte selects.
- i_wb_we  in  1  write enable.
- i_wb_cyc  in  1  cycle.
- i_wb_stb  in  1  strobe.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  acknowledge.
- o_an  out  NUM_DIGITS  digit anodes.
- o_seg  out  7  segments a..g, bit0 = a.
- o_dp  out  1  decimal point.
- o_frame_tick  out  1  one-cycle pulse when the scan index wraps to 0.

Behaviour:
- Reset (i_rst=0, asynchronous): all registers 0; o_wb_ack=0; o_wb_rdt=0; o_frame_tick=0; o_an/o_seg/o_dp inactive (all 1 when ACTIVE_LOW).
- Wishbone:
  - o_wb_ack asserts one cycle after cyc&stb&!ack, for exactly one cycle.
  - Write commits on the ack cycle and honours i_wb_sel per byte.
  - o_wb_rdt is valid on the ack cycle.
  - Unmapped reads return 0; unmapped writes are ignored.
- Register map:
  - 0x00 CTRL: [0] enable, [7:4] brightness, [23:16] blink_div (frames per half-period).
  - 0x04 DIGIT_EN [NUM_DIGITS-1:0].
  - 0x08 MODE: per digit, 1 = ASCII, 0 = hex nibble.
  - 0x0C DP: per digit.
  - 0x10 BLINK_MASK: per digit.
  - 0x20..0x2C DATA: digit i occupies byte i%4 of word 0x20+4*(i/4). Bytes beyond NUM_DIGITS read 0.
  - 0x30 STATUS (read-only): [3:0] scan index, [31:16] frame count.
  - Control bits above NUM_DIGITS read 0.
- Scan:
  - SLOT_DIV = CLK_FREQ_HZ/(REFRESH_HZ*NUM_DIGITS), minimum 1.
  - The prescaler counts 0..SLOT_DIV-1; at terminal count the scan index advances and wraps NUM_DIGITS-1 -> 0.
  - o_frame_tick pulses on the cycle the index wraps; the frame counter (16-bit, wraps) increments on the same cycle.
  - enable=0: prescaler and index are held at 0, anodes inactive, no ticks.
- Output stage:
  - Registered, 1-cycle latency from index/register change to o_an/o_seg/o_dp.
  - At most one anode is active at a time.
  - A register write takes effect on the pins on the next clock, including mid-slot.
- Digit lit condition: DIGIT_EN[idx] & pwm_on & !(BLINK_MASK[idx] & blink_off).
  - When not lit, anode, segments and dp are all inactive.
- PWM:
  - A 4-bit free-running counter pwm_cnt.
  - pwm_on = (brightness==15) | (pwm_cnt < brightness).
  - brightness 0 means blank.
- Blink:
  - The frame counter drives a half-period counter; blink_off toggles every blink_div frames.
  - blink_div=0 forces blink_off=0.
  - Changing blink_div resets the half-period counter.
- Decode:
  - Hex mode: low nibble 0-F, standard glyphs (b, d lowercase).
  - ASCII mode: '0'-'9', 'A'-'Z' and 'a'-'z' (case-folded, best-effort glyphs), '-', '_', space. Any other code is blank.
- A Wishbone access during reset is ignored and no ack is generated.

Decomposition:
- Package sevseg_pkg:
  - Register offset constants.
  - 7-bit glyph constants (GLYPH_BLANK, GLYPH_MINUS, ...).
  - A ctrl_t packed struct.
  - A function computing SLOT_DIV.
- Sub-module sevseg_glyph_rom: combinational (mode, 8-bit code) -> 7-bit active-high segments. Polarity is applied only in the output stage of the top module.

Test Plan (CLK_FREQ_HZ=8000, REFRESH_HZ=125, NUM_DIGITS=8, so SLOT_DIV=8):
- Reset, then read every register -> all 0, o_an=8'hFF, o_seg=7'h7F; every access acked exactly 1 cycle after stb.
- Write DATA0=0x04030201, DATA1=0x08070605, DIGIT_EN=0xFF, CTRL=0xF1 (enable, brightness 15) -> each anode low for 8 cycles in order 0..7; o_seg shows hex glyphs for digits 1..8; o_frame_tick pulses every 64 cycles.
- MODE=0x01, DATA0 byte0=0x41 ('A') -> digit 0 shows 7'b1110111 (active-high) / 7'h08 on the pins; code 0x7F -> blank.
- CTRL brightness=4 -> within the active slot the anode is low only when pwm_cnt<4 (4 of 16 cycles); brightness=0 -> o_an stays 8'hFF.
- BLINK_MASK=0x02, blink_div=2 -> digit 1 is blank for frames 2-3, lit for frames 4-5, and so on; other digits are unaffected.
- Byte-select write sel=4'b0010 to DATA0 -> only digit 1 changes. Assert i_rst low mid-slot -> outputs inactive immediately; after release, scan restarts at index 0 only once enable is rewritten.
